shift_seq_ctrl: RTL and testbench

Command sequencer for the bidirectional shift register datapath. It accepts a one-cycle command (parallel load value, direction, serial bit pattern, shift count). It then drives the register's load, shift-enable, direction and serial-input controls for exactly the programmed number of cycles, and reports completion. It sits between the register-transfer control logic and the shift register instance, which has no sequencing of its own.

---
 rtl/shift_seq_ctrl.sv | 128 ++++++++++++
 tb/tb_shift_seq_ctrl.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/shift_seq_ctrl.sv
// shift_seq_ctrl: command sequencer for a bidirectional shift register.
// It accepts a one-cycle command in IDLE and latches it. It then drives one
// parallel-load cycle followed by the programmed number of shift cycles, and
// signals completion with a one-cycle done pulse. Every output is a flop. Each
// output's next value is derived from the next state, so a strobe is visible
// during the same cycle in which its state is active.
module shift_seq_ctrl #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             dir,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] ser_bits,
  input  logic [CNT_W-1:0] count,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic             sr_load,
  output logic [WIDTH-1:0] sr_load_data,
  output logic             sr_shift_en,
  output logic             sr_sel,
  output logic             sr_in,
  output logic [CNT_W-1:0] shift_cnt
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHIFT, S_DONE} state_t;

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(WIDTH);

  state_t           state_reg, state_next;
  logic             dir_reg, dir_next;
  logic [WIDTH-1:0] load_reg, load_next;
  logic [WIDTH-1:0] bits_reg, bits_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [CNT_W-1:0] shift_cnt_reg, shift_cnt_next;
  logic             busy_reg, busy_next;
  logic             done_reg, done_next;
  logic             sr_load_reg, sr_load_next;
  logic             sr_shift_en_reg, sr_shift_en_next;
  logic             sr_in_reg, sr_in_next;

  // State, latched command and registered outputs; active-low sync reset wins.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg       <= S_IDLE;
      dir_reg         <= 1'b0;
      load_reg        <= '0;
      bits_reg        <= '0;
      cnt_reg         <= '0;
      shift_cnt_reg   <= '0;
      busy_reg        <= 1'b0;
      done_reg        <= 1'b0;
      sr_load_reg     <= 1'b0;
      sr_shift_en_reg <= 1'b0;
      sr_in_reg       <= 1'b0;
    end else begin
      state_reg       <= state_next;
      dir_reg         <= dir_next;
      load_reg        <= load_next;
      bits_reg        <= bits_next;
      cnt_reg         <= cnt_next;
      shift_cnt_reg   <= shift_cnt_next;
      busy_reg        <= busy_next;
      done_reg        <= done_next;
      sr_load_reg     <= sr_load_next;
      sr_shift_en_reg <= sr_shift_en_next;
      sr_in_reg       <= sr_in_next;
    end
  end

  // Next-state logic: abort only matters while a command is active.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:  if (start) state_next = S_LOAD;
      S_LOAD: begin
        if (abort)                 state_next = S_IDLE;
        else if (cnt_reg != '0)    state_next = S_SHIFT;
        else                       state_next = S_DONE;
      end
      S_SHIFT: begin
        if (abort)                                   state_next = S_IDLE;
        else if (shift_cnt_reg == cnt_reg - CNT_W'(1)) state_next = S_DONE;
      end
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Output logic: command latching, shift counting and next values of the strobes.
  always_comb begin
    dir_next       = dir_reg;
    load_next      = load_reg;
    bits_next      = bits_reg;
    cnt_next       = cnt_reg;
    shift_cnt_next = shift_cnt_reg;
    if (state_reg == S_IDLE && start) begin
      dir_next       = dir;
      load_next      = load_val;
      bits_next      = ser_bits;
      cnt_next       = (count > MAX_CNT) ? MAX_CNT : count;
      shift_cnt_next = '0;
    end
    // The shift in an abort cycle still reaches the register, so it is counted.
    if (state_reg == S_SHIFT) begin
      shift_cnt_next = shift_cnt_reg + CNT_W'(1);
    end
    busy_next        = (state_next != S_IDLE);
    done_next        = (state_next == S_DONE);
    sr_load_next     = (state_next == S_LOAD);
    sr_shift_en_next = (state_next == S_SHIFT);
    sr_in_next       = (state_next == S_SHIFT) &&
                       (|(bits_next & (WIDTH'(1) << shift_cnt_next)));
  end

  assign busy         = busy_reg;
  assign done         = done_reg;
  assign sr_load      = sr_load_reg;
  assign sr_load_data = load_reg;
  assign sr_shift_en  = sr_shift_en_reg;
  assign sr_sel       = dir_reg;
  assign sr_in        = sr_in_reg;
  assign shift_cnt    = shift_cnt_reg;

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Directed bench for shift_seq_ctrl (WIDTH=4, CNT_W=3). Inputs change 1 ns
// after a rising edge and outputs are sampled at that same point.
module tb_shift_seq_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       dir;
  logic [3:0] load_val;
  logic [3:0] ser_bits;
  logic [2:0] count;
  logic       abort;
  logic       busy;
  logic       done;
  logic       sr_load;
  logic [3:0] sr_load_data;
  logic       sr_shift_en;
  logic       sr_sel;
  logic       sr_in;
  logic [2:0] shift_cnt;

  int total = 0;
  int bad   = 0;
  logic [3:0] pat;

  shift_seq_ctrl #(.WIDTH(4), .CNT_W(3)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .dir          (dir),
    .load_val     (load_val),
    .ser_bits     (ser_bits),
    .count        (count),
    .abort        (abort),
    .busy         (busy),
    .done         (done),
    .sr_load      (sr_load),
    .sr_load_data (sr_load_data),
    .sr_shift_en  (sr_shift_en),
    .sr_sel       (sr_sel),
    .sr_in        (sr_in),
    .shift_cnt    (shift_cnt)
  );

  always #5 clk = ~clk;

  // Advance to 1 ns after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Check the full set of strobes for the cycle that has just begun.
  task automatic chk_strobes(input string tag, input logic b, input logic d,
                             input logic ld, input logic sh, input logic si);
    chk({tag, ".busy"},  {31'd0, busy},        {31'd0, b});
    chk({tag, ".done"},  {31'd0, done},        {31'd0, d});
    chk({tag, ".load"},  {31'd0, sr_load},     {31'd0, ld});
    chk({tag, ".shen"},  {31'd0, sr_shift_en}, {31'd0, sh});
    chk({tag, ".srin"},  {31'd0, sr_in},       {31'd0, si});
  endtask

  // Present a command for one accept edge, then drop start.
  task automatic cmd(input logic [3:0] lv, input logic d, input logic [3:0] sb, input logic [2:0] c);
    load_val = lv; dir = d; ser_bits = sb; count = c; start = 1'b1;
    step();
    start = 1'b0;
    $display("cmd load=%h dir=%0d bits=%b count=%0d", lv, d, sb, c);
  endtask

  initial begin
    reset = 1'b0; start = 1'b1; dir = 1'b1; load_val = 4'h3; ser_bits = 4'hF;
    count = 3'd0; abort = 1'b0;

    // Reset held two cycles with start high: nothing may start.
    step(); step();
    chk_strobes("rst", 0, 0, 0, 0, 0);
    chk("rst.data", {28'd0, sr_load_data}, 32'h0);
    chk("rst.sel",  {31'd0, sr_sel},       32'h0);
    chk("rst.cnt",  {29'd0, shift_cnt},    32'h0);
    reset = 1'b1;
    step();
    start = 1'b0;
    chk_strobes("rel.load", 1, 0, 1, 0, 0);
    chk("rel.data", {28'd0, sr_load_data}, 32'h3);
    step();
    chk_strobes("rel.done", 1, 1, 0, 0, 0);
    step();
    chk_strobes("rel.idle", 0, 0, 0, 0, 0);

    // Normal command: load 1010, dir 1, bits 0101, count 2.
    cmd(4'b1010, 1'b1, 4'b0101, 3'd2);
    load_val = 4'h0; ser_bits = 4'h0; dir = 1'b0; count = 3'd7;
    chk_strobes("nrm.c1", 1, 0, 1, 0, 0);
    chk("nrm.data", {28'd0, sr_load_data}, 32'hA);
    chk("nrm.sel",  {31'd0, sr_sel},       32'h1);
    step();
    chk_strobes("nrm.c2", 1, 0, 0, 1, 1);
    chk("nrm.sel2", {31'd0, sr_sel}, 32'h1);
    chk("nrm.cnt0", {29'd0, shift_cnt}, 32'h0);
    step();
    chk_strobes("nrm.c3", 1, 0, 0, 1, 0);
    chk("nrm.cnt1", {29'd0, shift_cnt}, 32'h1);
    step();
    chk_strobes("nrm.c4", 1, 1, 0, 0, 0);
    chk("nrm.cnt2", {29'd0, shift_cnt}, 32'h2);
    step();
    chk_strobes("nrm.idle", 0, 0, 0, 0, 0);
    chk("nrm.hold", {29'd0, shift_cnt}, 32'h2);
    chk("nrm.selh", {31'd0, sr_sel}, 32'h1);

    // Zero count: load then done, no shifting.
    cmd(4'h7, 1'b0, 4'hF, 3'd0);
    chk_strobes("z.load", 1, 0, 1, 0, 0);
    chk("z.cnt", {29'd0, shift_cnt}, 32'h0);
    step();
    chk_strobes("z.done", 1, 1, 0, 0, 0);
    step();
    chk_strobes("z.idle", 0, 0, 0, 0, 0);

    // Clamped count: 7 becomes 4 shifts of bits 1101 (LSB first: 1,0,1,1).
    pat = 4'b1101;
    cmd(4'h0, 1'b0, pat, 3'd7);
    chk_strobes("cl.load", 1, 0, 1, 0, 0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk_strobes($sformatf("cl.sh%0d", i), 1, 0, 0, 1, pat[i]);
      chk($sformatf("cl.cnt%0d", i), {29'd0, shift_cnt}, i);
    end
    step();
    chk_strobes("cl.done", 1, 1, 0, 0, 0);
    chk("cl.cnt", {29'd0, shift_cnt}, 32'h4);
    step();
    chk_strobes("cl.idle", 0, 0, 0, 0, 0);

    // Abort during the first shift of a count=4 command.
    cmd(4'h5, 1'b1, 4'b0011, 3'd4);
    chk_strobes("ab.load", 1, 0, 1, 0, 0);
    step();
    chk_strobes("ab.sh0", 1, 0, 0, 1, 1);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk_strobes("ab.idle", 0, 0, 0, 0, 0);
    chk("ab.cnt", {29'd0, shift_cnt}, 32'h1);
    cmd(4'h9, 1'b0, 4'b0001, 3'd1);
    chk_strobes("ab2.load", 1, 0, 1, 0, 0);
    chk("ab2.data", {28'd0, sr_load_data}, 32'h9);
    chk("ab2.cnt",  {29'd0, shift_cnt},    32'h0);
    step();
    chk_strobes("ab2.sh", 1, 0, 0, 1, 1);
    chk("ab2.sel", {31'd0, sr_sel}, 32'h0);
    step();
    chk_strobes("ab2.done", 1, 1, 0, 0, 0);
    chk("ab2.cnt1", {29'd0, shift_cnt}, 32'h1);
    step();
    chk_strobes("ab2.idle", 0, 0, 0, 0, 0);

    // start held high with other data through LOAD, SHIFT and DONE: ignored.
    cmd(4'hC, 1'b1, 4'b0110, 3'd2);
    start = 1'b1; load_val = 4'hF; dir = 1'b0; ser_bits = 4'b1001; count = 3'd3;
    chk_strobes("ig.load", 1, 0, 1, 0, 0);
    chk("ig.data", {28'd0, sr_load_data}, 32'hC);
    step();
    chk_strobes("ig.sh0", 1, 0, 0, 1, 0);
    chk("ig.sel", {31'd0, sr_sel}, 32'h1);
    step();
    chk_strobes("ig.sh1", 1, 0, 0, 1, 1);
    step();
    chk_strobes("ig.done", 1, 1, 0, 0, 0);
    chk("ig.cnt", {29'd0, shift_cnt}, 32'h2);
    step();
    start = 1'b0;
    chk_strobes("ig.idle", 0, 0, 0, 0, 0);
    chk("ig.data2", {28'd0, sr_load_data}, 32'hC);

    // Synchronous reset during SHIFT of a count=3 command, after 2 shifts.
    cmd(4'h6, 1'b1, 4'b1111, 3'd3);
    step();
    step();
    step();
    chk_strobes("rs.sh2", 1, 0, 0, 1, 1);
    chk("rs.cnt2", {29'd0, shift_cnt}, 32'h2);
    reset = 1'b0;
    step();
    chk_strobes("rs.rst", 0, 0, 0, 0, 0);
    chk("rs.cnt",  {29'd0, shift_cnt},    32'h0);
    chk("rs.data", {28'd0, sr_load_data}, 32'h0);
    chk("rs.sel",  {31'd0, sr_sel},       32'h0);
    reset = 1'b1;
    step();
    chk_strobes("rs.after", 0, 0, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
